// File: rtl/mips_bus_wait_injector.sv
// mips_bus_wait_injector: Avalon-MM wait-state injector between the CPU master port and a synchronous RAM
module mips_bus_wait_injector #(
  parameter int          READ_WAIT   = 2,
  parameter int          WRITE_WAIT  = 3,
  parameter int          RANDOM_MODE = 0,
  parameter logic [3:0]  RAND_MASK   = 4'hF,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_address,
  input  logic [3:0]  s_byteenable,
  input  logic [31:0] s_writedata,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [31:0] stall_count,
  output logic        protocol_error
);
  if (READ_WAIT < 1) begin : g_bad_read_wait
    $fatal(1, "READ_WAIT must be >= 1");
  end
  if (WRITE_WAIT < 0) begin : g_bad_write_wait
    $fatal(1, "WRITE_WAIT must be >= 0");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $fatal(1, "LFSR_SEED must be nonzero");
  end
  typedef enum logic [1:0] {IDLE, STALL, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, lfsr_q, lfsr_d, w;
  logic [31:0] rdata_q, rdata_d, stall_q, stall_d;
  logic        wr_q, wr_d, err_q, err_d;
  logic        req, abort, done;
  assign req = s_read | s_write;
  // A transfer in flight is aborted when the request vanishes or changes kind.
  assign abort = (state_q != IDLE) & (!req | (s_write != wr_q));
  assign w = 16'(s_write ? WRITE_WAIT : READ_WAIT) +
             ((RANDOM_MODE != 0) ? {12'd0, lfsr_q[3:0] & RAND_MASK} : 16'd0);
  assign m_address      = s_address;
  assign m_byteenable   = s_byteenable;
  assign m_writedata    = s_writedata;
  assign stall_count    = stall_q;
  assign protocol_error = err_q;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    lfsr_d        = lfsr_q;
    s_waitrequest = 1'b0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    s_readdata    = rdata_q;
    done          = 1'b0;
    if (abort) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (state_q == IDLE) begin
      if (req) begin
        wr_d          = s_write;
        err_d         = err_q | (s_read & s_write);
        done          = (w == 16'd0);
        m_write       = done;
        s_waitrequest = !done;
        m_read        = !s_write & (w == 16'd1);
        cnt_d         = w - 16'd1;
        state_d       = done ? IDLE : ((w == 16'd1) ? DONE : STALL);
      end
    end else if (state_q == STALL) begin
      s_waitrequest = 1'b1;
      m_read        = !wr_q & (cnt_q == 16'd1);
      cnt_d         = cnt_q - 16'd1;
      state_d       = (cnt_q == 16'd1) ? DONE : STALL;
    end else begin
      done       = 1'b1;
      m_write    = wr_q;
      s_readdata = wr_q ? rdata_q : m_readdata;
      rdata_d    = s_readdata;
      state_d    = IDLE;
    end
    if (done) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0);
    stall_d = (s_waitrequest && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    // No RAM strobe may escape in the cycle reset is being applied.
    if (reset) begin
      m_read  = 1'b0;
      m_write = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      lfsr_q  <= LFSR_SEED;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      lfsr_q  <= lfsr_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_mips_bus_wait_injector.sv
// tb_mips_bus_wait_injector: three injector instances (default, zero write wait, random) each on a byte-lane RAM
module tb_mips_bus_wait_injector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic        rd [3], wr [3], wt [3], mr [3], mw [3], perr [3];
  logic [31:0] addr [3], wdat [3], srd [3], maddr [3], mwd [3], mrd [3], scnt [3];
  logic [3:0]  be [3], mbe [3];
  logic [31:0] mem [3][64] = '{default: '0};
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_bus_wait_injector #(.WRITE_WAIT(g == 1 ? 0 : 3), .RANDOM_MODE(g == 2 ? 1 : 0)) u_dut (
      .clk(clk), .reset(reset), .s_read(rd[g]), .s_write(wr[g]), .s_address(addr[g]),
      .s_byteenable(be[g]), .s_writedata(wdat[g]), .s_waitrequest(wt[g]), .s_readdata(srd[g]),
      .m_read(mr[g]), .m_write(mw[g]), .m_address(maddr[g]), .m_byteenable(mbe[g]),
      .m_writedata(mwd[g]), .m_readdata(mrd[g]), .stall_count(scnt[g]), .protocol_error(perr[g]));
  end
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (mr[i]) mrd[i] <= mem[i][maddr[i][7:2]];
      if (mw[i])
        for (int b = 0; b < 4; b++)
          if (mbe[i][b]) mem[i][maddr[i][7:2]][8*b +: 8] <= mwd[i][8*b +: 8];
    end
  typedef struct { bit w; logic [31:0] a; logic [3:0] b; logic [31:0] d; int waits; logic [31:0] rdata; } vec_t;
  typedef struct { int waits; logic [31:0] rdata; int rd_n; int wr_n; int rd_cyc; int wr_cyc; } res_t;
  typedef struct { int waits; logic [31:0] rdata; bit w; } exp_t;
  exp_t sb [$];
  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic idle(input int d);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      idle(d);
      addr[d] = '0; be[d] = '0; wdat[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  // Drives one transfer starting right after a rising edge; returns right after the edge ending its completion cycle.
  task automatic xfer(input int d, input bit w, input bit r, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] dat, output res_t res);
    bit fin = 1'b0;
    res = '{-1, '0, 0, 0, -1, -1};
    rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wdat[d] = dat;
    for (int c = 0; c < 64 && !fin; c++) begin
      @(negedge clk);
      if (mr[d]) begin res.rd_n++; res.rd_cyc = c; end
      if (mw[d]) begin res.wr_n++; res.wr_cyc = c; end
      if (!wt[d]) begin
        res.waits = c;
        res.rdata = srd[d];
        fin = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!fin) chk("xfer_timeout", 32'd1, 32'd0);
  endtask
  task automatic cmp(input string nm, input res_t r);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_waits"}, r.waits, e.waits);
    chk({nm, "_wr_n"}, r.wr_n, e.w ? 1 : 0);
    chk({nm, "_rd_n"}, r.rd_n, e.w ? 0 : 1);
    if (e.w) chk({nm, "_wr_cyc"}, r.wr_cyc, e.waits);
    else begin
      chk({nm, "_rd_cyc"}, r.rd_cyc, e.waits - 1);
      chk({nm, "_rdata"}, r.rdata, e.rdata);
    end
  endtask
  task automatic drop_read(input int d);
    int n = 0;
    rd[d] = 1'b1; addr[d] = 32'h10; be[d] = 4'hF;
    @(negedge clk);
    @(posedge clk);
    #1 rd[d] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n += int'(mr[d]);
      @(posedge clk);
      #1;
    end
    chk("drop_no_mread", n, 0);
    @(negedge clk);
    chk("drop_perr", perr[d], 1'b1);
    @(posedge clk);
    #1;
  endtask
  vec_t tbl [10];
  res_t r, r2;
  int exp_stall, n, bad, diff, ew;
  int seq [1000];
  logic [15:0] m;
  initial begin
    tbl = '{
      '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 3, 32'h0},
      '{1'b0, 32'h10, 4'hF, 32'h0,        2, 32'hDEADBEEF},
      '{1'b1, 32'h20, 4'h3, 32'h12345678, 3, 32'h0},
      '{1'b0, 32'h20, 4'hF, 32'h0,        2, 32'h00005678},
      '{1'b1, 32'h24, 4'hF, 32'hCAFEF00D, 3, 32'h0},
      '{1'b1, 32'h24, 4'hC, 32'hAAAA5555, 3, 32'h0},
      '{1'b0, 32'h24, 4'hF, 32'h0,        2, 32'hAAAAF00D},
      '{1'b1, 32'h28, 4'h0, 32'hFFFFFFFF, 3, 32'h0},
      '{1'b0, 32'h28, 4'hF, 32'h0,        2, 32'h0},
      '{1'b0, 32'h10, 4'hF, 32'h0,        2, 32'hDEADBEEF}};
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_stall", scnt[d], 32'd0);
      chk("rst_perr", perr[d], 1'b0);
      chk("rst_rdata", srd[d], 32'd0);
      chk("rst_wait", wt[d], 1'b0);
      chk("rst_strobes", {mr[d], mw[d]}, 2'b00);
    end
    @(posedge clk);
    #1;
    exp_stall = 0;
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{tbl[i].waits, tbl[i].rdata, tbl[i].w});
      exp_stall += tbl[i].waits;
      xfer(0, tbl[i].w, !tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, r);
      idle(0);
      cmp($sformatf("vec%0d", i), r);
      @(negedge clk);
      chk("idle_wait", wt[0], 1'b0);
      @(posedge clk);
      #1;
    end
    chk("table_stall", scnt[0], exp_stall);
    chk("table_perr", perr[0], 1'b0);
    // Back-to-back read then write with no idle gap.
    do_reset();
    sb.push_back('{2, 32'hDEADBEEF, 1'b0});
    sb.push_back('{3, 32'h0, 1'b1});
    xfer(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'h0, r);
    xfer(0, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0BADCAFE, r2);
    idle(0);
    cmp("b2b_rd", r);
    cmp("b2b_wr", r2);
    @(negedge clk);
    chk("b2b_stall", scnt[0], 32'd5);
    chk("b2b_perr", perr[0], 1'b0);
    @(posedge clk);
    #1;
    // Reset asserted in cycle 1 of a write.
    n = 0;
    wr[0] = 1'b1; addr[0] = 32'h34; be[0] = 4'hF; wdat[0] = 32'h55;
    @(negedge clk);
    n += int'(mw[0]);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n += int'(mw[0]);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(0);
    repeat (5) begin
      @(negedge clk);
      n += int'(mw[0]);
      @(posedge clk);
      #1;
    end
    chk("rstmid_no_mwrite", n, 0);
    @(negedge clk);
    chk("rstmid_stall", scnt[0], 32'd0);
    chk("rstmid_rdata", srd[0], 32'd0);
    @(posedge clk);
    #1;
    sb.push_back('{2, 32'h0, 1'b0});
    xfer(0, 1'b0, 1'b1, 32'h34, 4'hF, 32'h0, r);
    idle(0);
    cmp("rstmid_readback", r);
    // Read and write asserted together act as a write and flag an error.
    do_reset();
    sb.push_back('{3, 32'h0, 1'b1});
    xfer(0, 1'b1, 1'b1, 32'h38, 4'hF, 32'h77, r);
    idle(0);
    cmp("both_rw", r);
    @(negedge clk);
    chk("both_perr", perr[0], 1'b1);
    @(posedge clk);
    #1;
    do_reset();
    drop_read(0);
    // Zero-wait writes, back to back.
    do_reset();
    sb.push_back('{0, 32'h0, 1'b1});
    sb.push_back('{0, 32'h0, 1'b1});
    xfer(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h11112222, r);
    xfer(1, 1'b1, 1'b0, 32'h44, 4'hF, 32'h33334444, r2);
    idle(1);
    cmp("w0_a", r);
    cmp("w0_b", r2);
    @(negedge clk);
    chk("w0_stall", scnt[1], 32'd0);
    @(posedge clk);
    #1;
    sb.push_back('{2, 32'h11112222, 1'b0});
    sb.push_back('{2, 32'h33334444, 1'b0});
    xfer(1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h0, r);
    xfer(1, 1'b0, 1'b1, 32'h44, 4'hF, 32'h0, r2);
    idle(1);
    cmp("w0_rd_a", r);
    cmp("w0_rd_b", r2);
    @(negedge clk);
    chk("w0_rd_stall", scnt[1], 32'd4);
    @(posedge clk);
    #1;
    // Random mode: stall lengths follow the 0xB400 Galois LFSR and repeat after reset.
    bad = 0;
    diff = 0;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      m = 16'hACE1;
      for (int i = 0; i < 1000; i++) begin
        ew = 2 + int'(m[3:0]);
        xfer(2, 1'b0, 1'b1, 32'h40, 4'hF, 32'h0, r);
        if (p == 0) begin
          chk("rand_w", r.waits, ew);
          seq[i] = r.waits;
          if (r.waits < 2 || r.waits > 17) bad++;
        end else if (seq[i] != r.waits) diff++;
        m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0);
      end
      idle(2);
      @(posedge clk);
      #1;
    end
    chk("rand_range", bad, 0);
    chk("rand_repeat", diff, 0);
    drop_read(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
